// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle main control FSM for the 2-bit ALU datapath
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       extop,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_RTEX   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BEQEX  = 4'd8,
      ST_IMMEX  = 4'd9,
      ST_JEX    = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_AND  = 6'b100100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_EXT  = 2'b10;
   localparam logic [1:0] SRCB_BOFS = 2'b11;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   logic [3:0] state_q;
   state_t     state_d;

   logic       funct_legal;
   logic       pcwrite;
   logic       branch;
   logic       irwrite_raw;
   logic       regwrite_raw;
   logic       memwrite_raw;

   // Only the four supported R-type functions are allowed through DECODE.
   always_comb begin
      funct_legal = 1'b0;
      case (funct)
         FN_ADDU, FN_SUBU, FN_OR, FN_AND: funct_legal = 1'b1;
         default:                         funct_legal = 1'b0;
      endcase
   end

   // State register; reset returns to FETCH immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection; undefined encodings fall back to FETCH.
   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:      state_d = ST_MEMADR;
               OP_RTYPE:          state_d = funct_legal ? ST_RTEX : ST_FETCH;
               OP_BEQ:            state_d = ST_BEQEX;
               OP_ADDIU, OP_ORI:  state_d = ST_IMMEX;
               OP_J:              state_d = ST_JEX;
               default:           state_d = ST_FETCH;
            endcase
         end
         ST_MEMADR: begin
            if (opcode == OP_LW) begin
               state_d = ST_MEMRD;
            end else if (opcode == OP_SW) begin
               state_d = ST_MEMWR;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_MEMRD:  state_d = ST_MEMWB;
         ST_MEMWB:  state_d = ST_FETCH;
         ST_MEMWR:  state_d = ST_FETCH;
         ST_RTEX:   state_d = ST_ALUWB;
         ST_IMMEX:  state_d = ST_ALUWB;
         ST_ALUWB:  state_d = ST_FETCH;
         ST_BEQEX:  state_d = ST_FETCH;
         ST_JEX:    state_d = ST_FETCH;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Per-state datapath controls; everything not named in a state stays 0.
   always_comb begin
      iord         = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = SRCB_REG;
      extop        = 1'b0;
      aluop        = ALU_ADD;
      pcsrc        = PCSRC_ALU;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      case (state_q)
         ST_FETCH: begin
            alusrcb     = SRCB_FOUR;
            irwrite_raw = 1'b1;
            pcwrite     = 1'b1;
         end
         ST_DECODE: begin
            // Precompute the branch target into ALUOut while decoding.
            alusrcb = SRCB_BOFS;
            extop   = 1'b1;
         end
         ST_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_EXT;
            extop   = 1'b1;
         end
         ST_MEMRD: begin
            iord = 1'b1;
         end
         ST_MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
         end
         ST_MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         ST_RTEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_REG;
            case (funct)
               FN_SUBU: aluop = ALU_SUB;
               FN_OR:   aluop = ALU_OR;
               FN_AND:  aluop = ALU_AND;
               default: aluop = ALU_ADD;
            endcase
         end
         ST_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_EXT;
            if (opcode == OP_ORI) begin
               extop = 1'b0;
               aluop = ALU_OR;
            end else if (opcode == OP_ADDIU) begin
               extop = 1'b1;
               aluop = ALU_ADD;
            end
         end
         ST_ALUWB: begin
            regdst       = (opcode == OP_RTYPE);
            regwrite_raw = 1'b1;
         end
         ST_BEQEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_REG;
            aluop   = ALU_SUB;
            pcsrc   = PCSRC_OUT;
            branch  = 1'b1;
         end
         ST_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: begin
            iord = 1'b0;
         end
      endcase
   end

   // Architectural enables are killed combinationally while reset is high.
   always_comb begin
      pcen     = ~reset & (pcwrite | (branch & zero));
      irwrite  = ~reset & irwrite_raw;
      regwrite = ~reset & regwrite_raw;
      memwrite = ~reset & memwrite_raw;
      state    = state_q;
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against an instruction-level model
module tb_mc_ctrl;

   typedef struct packed {
      logic       pcen;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       extop;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic [3:0] state;
   } outs_t;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, extop;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;
   outs_t      dut_o;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic       chk_en   = 1'b0;
   int         exp_st   = 0;
   int         rw_cnt   = 0;
   int         mw_cnt   = 0;
   outs_t      hist[$];

   mc_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop), .aluop(aluop),
      .pcsrc(pcsrc), .state(state)
   );

   assign dut_o = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, extop, aluop, pcsrc, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Instruction class: 0 lw, 1 sw, 2 R-type, 3 addiu/ori, 4 beq, 5 j, 6 unsupported
   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b100011: return 0;
         6'b101011: return 1;
         6'b000000: return (fn == 6'b100001 || fn == 6'b100011 ||
                            fn == 6'b100101 || fn == 6'b100100) ? 2 : 6;
         6'b001001, 6'b001101: return 3;
         6'b000100: return 4;
         6'b000010: return 5;
         default: return 6;
      endcase
   endfunction

   // Expected control word for a given state, taken from the per-state table.
   function automatic outs_t model_out(input int st, input logic [5:0] op,
                                      input logic [5:0] fn, input logic z);
      outs_t o;
      o = '0;
      o.state = st[3:0];
      case (st)
         0:  begin o.alusrcb = 2'b01; o.irwrite = 1'b1; o.pcen = 1'b1; end
         1:  begin o.alusrcb = 2'b11; o.extop = 1'b1; end
         2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.extop = 1'b1; end
         3:  o.iord = 1'b1;
         4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
         5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
         6:  begin
                o.alusrca = 1'b1;
                o.aluop = (fn == 6'b100011) ? 2'b01 : (fn == 6'b100101) ? 2'b10 :
                          (fn == 6'b100100) ? 2'b11 : 2'b00;
             end
         7:  begin o.regdst = (op == 6'b000000); o.regwrite = 1'b1; end
         8:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z; end
         9:  begin
                o.alusrca = 1'b1; o.alusrcb = 2'b10;
                o.extop = (op == 6'b001001);
                o.aluop = (op == 6'b001101) ? 2'b10 : 2'b00;
             end
         10: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
         default: o.state = st[3:0];
      endcase
      return o;
   endfunction

   // Per-cycle compare against the model while an instruction is being tracked.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle_outs", 32'(dut_o), 32'(model_out(exp_st, opcode, funct, zero)));
         hist.push_back(dut_o);
         if (regwrite) rw_cnt++;
         if (memwrite) mw_cnt++;
      end
   end

   // Runs one instruction starting in FETCH just after a rising edge.
   // zsel: 0/1 fixed zero flag, 2 random per cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel);
      int seq[$];
      int cls;
      cls = classify(op, fn);
      case (cls)
         0: seq = '{0, 1, 2, 3, 4};
         1: seq = '{0, 1, 2, 5};
         2: seq = '{0, 1, 6, 7};
         3: seq = '{0, 1, 9, 7};
         4: seq = '{0, 1, 8};
         5: seq = '{0, 1, 10};
         default: seq = '{0, 1};
      endcase
      opcode = op;
      funct  = fn;
      rw_cnt = 0;
      mw_cnt = 0;
      hist.delete();
      chk_en = 1'b1;
      foreach (seq[i]) begin
         exp_st = seq[i];
         zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
      check("regwrite_pulses", rw_cnt, (cls == 0 || cls == 2 || cls == 3) ? 1 : 0);
      check("memwrite_pulses", mw_cnt, (cls == 1) ? 1 : 0);
      check("back_in_fetch", state, 0);
   endtask

   initial begin
      logic [5:0] ops[9];
      logic [5:0] fns[5];
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b001001,
              6'b001101, 6'b000100, 6'b000010, 6'b111111};
      fns = '{6'b100001, 6'b100011, 6'b100101, 6'b100100, 6'b000000};

      reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", state, 0);
      check("rst_pcen", pcen, 0);
      check("rst_irwrite", irwrite, 0);
      check("rst_alusrcb", alusrcb, 2'b01);
      reset = 1'b0;

      // lw
      run_instr(6'b100011, 6'd0, 0);
      check("lw_cycles", hist.size(), 5);
      check("lw_memrd_iord", hist[3].iord, 1);
      check("lw_memwb_regwrite", hist[4].regwrite, 1);
      check("lw_memwb_memtoreg", hist[4].memtoreg, 1);
      check("lw_memwb_regdst", hist[4].regdst, 0);

      // subu
      run_instr(6'b000000, 6'b100011, 2);
      check("subu_cycles", hist.size(), 4);
      check("subu_rtex_aluop", hist[2].aluop, 2'b01);
      check("subu_rtex_alusrca", hist[2].alusrca, 1);
      check("subu_rtex_alusrcb", hist[2].alusrcb, 2'b00);
      check("subu_aluwb_regdst", hist[3].regdst, 1);

      // ori
      run_instr(6'b001101, 6'd0, 2);
      check("ori_immex_aluop", hist[2].aluop, 2'b10);
      check("ori_immex_extop", hist[2].extop, 0);
      check("ori_immex_alusrcb", hist[2].alusrcb, 2'b10);
      check("ori_aluwb_regdst", hist[3].regdst, 0);

      // beq taken / not taken
      run_instr(6'b000100, 6'd0, 1);
      check("beq_t_cycles", hist.size(), 3);
      check("beq_t_pcen", hist[2].pcen, 1);
      check("beq_t_pcsrc", hist[2].pcsrc, 2'b01);
      check("beq_t_aluop", hist[2].aluop, 2'b01);
      run_instr(6'b000100, 6'd0, 0);
      check("beq_nt_pcen", hist[2].pcen, 0);

      // unsupported opcode and illegal funct
      run_instr(6'b111111, 6'd0, 1);
      check("badop_cycles", hist.size(), 2);
      check("badop_decode_pcen", hist[1].pcen, 0);
      run_instr(6'b000000, 6'b000000, 1);
      check("badfn_cycles", hist.size(), 2);

      // reset pulse in the middle of MEMRD
      opcode = 6'b100011;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("pre_rst_memrd", state, 3);
      #2 reset = 1'b1;
      #1;
      check("midrst_state", state, 0);
      check("midrst_regwrite", regwrite, 0);
      check("midrst_memwrite", memwrite, 0);
      check("midrst_irwrite", irwrite, 0);
      check("midrst_pcen", pcen, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("post_rst_irwrite", irwrite, 1);
      check("post_rst_pcen", pcen, 1);
      check("post_rst_alusrcb", alusrcb, 2'b01);
      @(posedge clk);
      #1;
      check("post_rst_decode", state, 1);
      opcode = 6'b111111;
      @(posedge clk);
      #1;
      check("post_rst_fetch", state, 0);

      // undefined encoding 13
      force dut.state_q = 4'd13;
      #1;
      check("st13_state", state, 13);
      check("st13_outs", 32'(dut_o), 32'(model_out(13, opcode, funct, 1'b1)));
      #1 release dut.state_q;
      @(posedge clk);
      #1;
      check("st13_to_fetch", state, 0);

      // randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         int k;
         logic [5:0] op;
         logic [5:0] fn;
         k  = $urandom_range(0, 9);
         op = (k == 9) ? 6'($urandom_range(0, 63)) : ops[k];
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
         run_instr(op, fn, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
